get_param_seq: RTL and testbench
================================

GET_PARAM_SEQ -- requirements
Module: get_param_seq

Interface
REQ-001 Parameter PARAM_W, default 8: width of each of i/z/k/l fields.
REQ-002 Parameter ADDR_W, default 12: regfile address width.
REQ-003 Parameter POS_W, default 4: position field width; all-ones position = terminal record.
REQ-004 Parameter DEPTH, default 4096: valid regfile entries (0..DEPTH-1).
REQ-005 clk  in  1  sole clock; all logic on rising edge.
REQ-006 rst  in  1  reset, synchronous, active-high.
REQ-007 start  in  1  begin walk; ignored unless idle.
REQ-008 start_addr  in  ADDR_W  first record address.
REQ-009 busy  out  1  high from the cycle after an accepted start until done.
REQ-010 done  out  1  one-cycle pulse when the walk ends.
REQ-011 err  out  1  sticky range error (see Configuration).
REQ-012 ir_rdata  in  4*PARAM_W  InexRecur word: {i,z,k,l}, i in MSBs.
REQ-013 ir_rd_seq / ir_rd_ran  out  1 each  sequential / random read strobes.
REQ-014 ir_rd_addr  out  ADDR_W  random read address.
REQ-015 ir_cur_addr  in  ADDR_W  address of the word on ir_rdata.
REQ-016 st_rdata  in  1+ADDR_W+POS_W  state word {jump, target, pos}.
REQ-017 st_rd_seq / st_rd_ran / st_rd_addr / st_cur_addr: the same as REQ-013..015, for the state regfile.
REQ-018 out_valid  out  1; out_ready  in  1: output handshake.
REQ-019 i_out, z_out, k_out, l_out  out  PARAM_W each; addr_out  out  ADDR_W; pos_out  out  POS_W.

Function
REQ-020 Both regfiles are read in lockstep: identical strobes and address in the same cycle; rdata is valid the cycle after a strobe.
REQ-021 Every strobe is high for exactly one cycle; seq and ran are never high together.
REQ-022 FSM states: IDLE, FETCH, CAPT, OUT, FIN.
REQ-023 IDLE: start=1 -> FETCH; ran strobes=1, rd_addr=start_addr.
REQ-024 FETCH -> CAPT unconditionally (the data-return cycle).
REQ-025 CAPT: registers ir_rdata fields, ir_cur_addr into addr_out, pos, jump and target; -> OUT.
REQ-026 OUT: out_valid=1; outputs held stable until out_valid&&out_ready.
REQ-027 On handshake with a terminal pos (all ones) or a range error -> FIN; otherwise -> FETCH.
REQ-028 Non-terminal handshake with jump=1: issue ran strobes with rd_addr=target in the same cycle as the transition.
REQ-029 Non-terminal handshake with jump=0: issue seq strobes.
REQ-030 FIN: done=1 for one cycle, busy=0; -> IDLE.
REQ-031 Latency: start to first out_valid = 3 cycles; peak throughput = one record per 3 cycles.
REQ-032 out_valid falls in the cycle after the handshake.
REQ-033 Output registers keep their last values outside OUT.
REQ-034 start is ignored while busy; start asserted in the FIN cycle is also ignored.
REQ-035 A terminal record is still presented on the output before done.
REQ-036 Sequential address wrap-around is owned by the regfile; this block only reports ir_cur_addr.

Reset
REQ-037 rst=1 at a clock edge forces IDLE, with all outputs, strobes, addresses and err = 0, including mid-walk.
REQ-038 No done pulse is generated for a walk aborted by reset.

Configuration
REQ-039 Macro GET_PARAM_RANGE_CHK_EN.
REQ-040 Defined: in CAPT, jump=1 with target>=DEPTH sets err=1. The record is output normally, then the walk ends via FIN. err clears on the next accepted start or on reset.
REQ-041 Undefined: err is tied 0 and target is used unchecked.

Verification
REQ-042 start_addr=0x010, regfile st[0x010]={0,x,0x0}, ir[0x010]=0x01020304, out_ready=1 -> out_valid at cycle+3; i/z/k/l=01/02/03/04; addr_out=0x010.
REQ-043 st[0x010]={1,0x200,0x1}, st[0x200]={0,x,0xF} -> ran strobe at 0x200, 2 records out, done pulses 1 cycle after the second handshake.
REQ-044 out_ready held 0 for 5 cycles in OUT -> outputs stable, no strobes; release -> next fetch proceeds.
REQ-045 rst asserted in CAPT -> next cycle all outputs 0, IDLE; no done pulse.
REQ-046 With macro defined, DEPTH=256, jump target=0x300 -> err=1, one record out, done pulse; the next start clears err.

Source files
------------

// File: rtl/get_param_seq_if.sv
// Read buses of the InexRecur and state regfiles plus the parameter output
// handshake. master = get_param_seq, slave = regfiles and consumer.
interface get_param_seq_if #(
    parameter int PARAM_W = 8,
    parameter int ADDR_W  = 12,
    parameter int POS_W   = 4
);
    localparam int ST_W = 1 + ADDR_W + POS_W;

    logic [4*PARAM_W-1:0] ir_rdata;
    logic                 ir_rd_seq;
    logic                 ir_rd_ran;
    logic [ADDR_W-1:0]    ir_rd_addr;
    logic [ADDR_W-1:0]    ir_cur_addr;

    logic [ST_W-1:0]      st_rdata;
    logic                 st_rd_seq;
    logic                 st_rd_ran;
    logic [ADDR_W-1:0]    st_rd_addr;
    logic [ADDR_W-1:0]    st_cur_addr;

    logic                 out_valid;
    logic                 out_ready;
    logic [PARAM_W-1:0]   i_out;
    logic [PARAM_W-1:0]   z_out;
    logic [PARAM_W-1:0]   k_out;
    logic [PARAM_W-1:0]   l_out;
    logic [ADDR_W-1:0]    addr_out;
    logic [POS_W-1:0]     pos_out;

    modport master (
        input  ir_rdata, ir_cur_addr, st_rdata, st_cur_addr, out_ready,
        output ir_rd_seq, ir_rd_ran, ir_rd_addr,
        output st_rd_seq, st_rd_ran, st_rd_addr,
        output out_valid, i_out, z_out, k_out, l_out, addr_out, pos_out
    );

    modport slave (
        output ir_rdata, ir_cur_addr, st_rdata, st_cur_addr, out_ready,
        input  ir_rd_seq, ir_rd_ran, ir_rd_addr,
        input  st_rd_seq, st_rd_ran, st_rd_addr,
        input  out_valid, i_out, z_out, k_out, l_out, addr_out, pos_out
    );
endinterface

// File: rtl/get_param_seq.sv
// Walks linked parameter records across the InexRecur and state regfiles.
// Optional target range check: define GET_PARAM_RANGE_CHK_EN.
module get_param_seq #(
    parameter int PARAM_W = 8,
    parameter int ADDR_W  = 12,
    parameter int POS_W   = 4,
    parameter int DEPTH   = 4096
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    output logic              busy,
    output logic              done,
    output logic              err,
    get_param_seq_if.master   bus
);
    localparam int ST_W = 1 + ADDR_W + POS_W;

    if (DEPTH < 1 || DEPTH > (1 << ADDR_W)) begin : g_bad_depth
        $error("DEPTH does not fit the regfile address space");
    end

    typedef enum logic [2:0] {IDLE, FETCH, CAPT, OUT, FIN} state_t;

    state_t            state;
    logic              rd_seq;
    logic              rd_ran;
    logic [ADDR_W-1:0] rd_addr;
    logic              jump_q;
    logic [ADDR_W-1:0] target_q;
    logic              stop_walk;

    logic              st_jump;
    logic [ADDR_W-1:0] st_target;
    logic [POS_W-1:0]  st_pos;

    assign st_jump   = bus.st_rdata[ST_W-1];
    assign st_target = bus.st_rdata[POS_W +: ADDR_W];
    assign st_pos    = bus.st_rdata[POS_W-1:0];

    // Both regfiles are driven from the same registers so they stay in lockstep.
    assign bus.ir_rd_seq  = rd_seq;
    assign bus.ir_rd_ran  = rd_ran;
    assign bus.ir_rd_addr = rd_addr;
    assign bus.st_rd_seq  = rd_seq;
    assign bus.st_rd_ran  = rd_ran;
    assign bus.st_rd_addr = rd_addr;

`ifdef GET_PARAM_RANGE_CHK_EN
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);
    logic err_q;
    logic range_bad;
    assign range_bad = st_jump && ({1'b0, st_target} >= DEPTH_L);
    assign err       = err_q;
    assign stop_walk = (&bus.pos_out) || err_q;
`else
    assign err       = 1'b0;
    assign stop_walk = &bus.pos_out;
`endif

    // NOTE: all state uses non-blocking assignments so every register samples
    // pre-edge values; the output data registers are reset too since reset
    // must clear every output.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            busy          <= 1'b0;
            done          <= 1'b0;
            rd_seq        <= 1'b0;
            rd_ran        <= 1'b0;
            rd_addr       <= '0;
            jump_q        <= 1'b0;
            target_q      <= '0;
            bus.out_valid <= 1'b0;
            bus.i_out     <= '0;
            bus.z_out     <= '0;
            bus.k_out     <= '0;
            bus.l_out     <= '0;
            bus.addr_out  <= '0;
            bus.pos_out   <= '0;
`ifdef GET_PARAM_RANGE_CHK_EN
            err_q         <= 1'b0;
`endif
        end else begin
            rd_seq <= 1'b0;
            rd_ran <= 1'b0;
            done   <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state   <= FETCH;
                        busy    <= 1'b1;
                        rd_ran  <= 1'b1;
                        rd_addr <= start_addr;
`ifdef GET_PARAM_RANGE_CHK_EN
                        err_q   <= 1'b0;
`endif
                    end
                end
                FETCH: state <= CAPT;
                CAPT: begin
                    {bus.i_out, bus.z_out, bus.k_out, bus.l_out} <= bus.ir_rdata;
                    bus.addr_out  <= bus.ir_cur_addr;
                    bus.pos_out   <= st_pos;
                    jump_q        <= st_jump;
                    target_q      <= st_target;
                    bus.out_valid <= 1'b1;
                    state         <= OUT;
`ifdef GET_PARAM_RANGE_CHK_EN
                    if (range_bad) err_q <= 1'b1;
`endif
                end
                OUT: begin
                    if (bus.out_ready) begin
                        bus.out_valid <= 1'b0;
                        if (stop_walk) begin
                            state <= FIN;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            state <= FETCH;
                            if (jump_q) begin
                                rd_ran  <= 1'b1;
                                rd_addr <= target_q;
                            end else begin
                                rd_seq  <= 1'b1;
                            end
                        end
                    end
                end
                FIN:     state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_get_param_seq.sv
// Directed bench for get_param_seq: behavioural regfiles plus hand-computed
// expectations for single records, jumps, stalls, reset aborts and range errors.
module tb_get_param_seq;
    localparam int PARAM_W = 8;
    localparam int ADDR_W  = 12;
    localparam int POS_W   = 4;
    localparam int DEPTH   = 256;
    localparam int ST_W    = 1 + ADDR_W + POS_W;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [ADDR_W-1:0] start_addr;
    logic              busy;
    logic              done;
    logic              err;

    int n_checks = 0;
    int n_err    = 0;
    int lockstep_bad = 0;

    logic [4*PARAM_W-1:0] ir_mem [0:(1<<ADDR_W)-1];
    logic [ST_W-1:0]      st_mem [0:(1<<ADDR_W)-1];

    get_param_seq_if #(.PARAM_W(PARAM_W), .ADDR_W(ADDR_W), .POS_W(POS_W)) bus ();

    get_param_seq #(
        .PARAM_W(PARAM_W), .ADDR_W(ADDR_W), .POS_W(POS_W), .DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .start_addr(start_addr),
        .busy(busy), .done(done), .err(err), .bus(bus)
    );

    always #5 clk = ~clk;

    // Regfile model: data and current address appear the cycle after a strobe.
    always @(posedge clk) begin
        if (bus.ir_rd_ran) begin
            bus.ir_cur_addr <= bus.ir_rd_addr;
            bus.ir_rdata    <= ir_mem[bus.ir_rd_addr];
        end else if (bus.ir_rd_seq) begin
            bus.ir_cur_addr <= bus.ir_cur_addr + 12'd1;
            bus.ir_rdata    <= ir_mem[bus.ir_cur_addr + 12'd1];
        end
        if (bus.st_rd_ran) begin
            bus.st_cur_addr <= bus.st_rd_addr;
            bus.st_rdata    <= st_mem[bus.st_rd_addr];
        end else if (bus.st_rd_seq) begin
            bus.st_cur_addr <= bus.st_cur_addr + 12'd1;
            bus.st_rdata    <= st_mem[bus.st_cur_addr + 12'd1];
        end
        if (!rst && ((bus.ir_rd_seq !== bus.st_rd_seq) || (bus.ir_rd_ran !== bus.st_rd_ran) ||
                     (bus.ir_rd_addr !== bus.st_rd_addr) || (bus.ir_rd_seq && bus.ir_rd_ran)))
            lockstep_bad++;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic nc();
        @(negedge clk);
    endtask

    initial begin
        for (int a = 0; a < (1 << ADDR_W); a++) begin
            ir_mem[a] = '0;
            st_mem[a] = '0;
        end
        ir_mem[12'h010] = 32'h01020304; st_mem[12'h010] = {1'b0, 12'h000, 4'h0};
        ir_mem[12'h011] = 32'h11121314; st_mem[12'h011] = {1'b0, 12'h000, 4'hF};
        ir_mem[12'h020] = 32'hAABBCCDD; st_mem[12'h020] = {1'b1, 12'h200, 4'h1};
        ir_mem[12'h200] = 32'h55667788; st_mem[12'h200] = {1'b0, 12'h000, 4'hF};
        ir_mem[12'h030] = 32'h0A0B0C0D; st_mem[12'h030] = {1'b1, 12'h300, 4'h2};
        ir_mem[12'h300] = 32'h01010101; st_mem[12'h300] = {1'b0, 12'h000, 4'hF};
        bus.ir_rdata = '0; bus.ir_cur_addr = '0;
        bus.st_rdata = '0; bus.st_cur_addr = '0;

        rst = 1'b1; start = 1'b0; start_addr = '0; bus.out_ready = 1'b1;
        repeat (3) nc();
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_valid", bus.out_valid, 0);
        check("rst_ran", bus.ir_rd_ran, 0);
        check("rst_seq", bus.ir_rd_seq, 0);
        check("rst_addr", bus.ir_rd_addr, 0);
        check("rst_i", bus.i_out, 0);
        rst = 1'b0;
        nc();

        // Two sequential records, terminal second.
        start = 1'b1; start_addr = 12'h010;
        nc();
        start = 1'b0;
        check("t1_busy", busy, 1);
        check("t1_ran", bus.ir_rd_ran, 1);
        check("t1_st_ran", bus.st_rd_ran, 1);
        check("t1_rd_addr", bus.ir_rd_addr, 12'h010);
        check("t1_valid_fetch", bus.out_valid, 0);
        nc();
        check("t1_ran_pulse", bus.ir_rd_ran, 0);
        check("t1_valid_capt", bus.out_valid, 0);
        nc();
        check("t1_valid", bus.out_valid, 1);
        check("t1_i", bus.i_out, 8'h01);
        check("t1_z", bus.z_out, 8'h02);
        check("t1_k", bus.k_out, 8'h03);
        check("t1_l", bus.l_out, 8'h04);
        check("t1_addr_out", bus.addr_out, 12'h010);
        check("t1_pos", bus.pos_out, 4'h0);
        nc();
        check("t1_valid_fall", bus.out_valid, 0);
        check("t1_seq", bus.ir_rd_seq, 1);
        check("t1_seq_ran", bus.ir_rd_ran, 0);
        check("t1_busy_mid", busy, 1);
        nc(); nc();
        check("t1_valid2", bus.out_valid, 1);
        check("t1_i2", bus.i_out, 8'h11);
        check("t1_addr_out2", bus.addr_out, 12'h011);
        check("t1_pos2", bus.pos_out, 4'hF);
        check("t1_no_done", done, 0);
        nc();
        check("t1_done", done, 1);
        check("t1_busy_fin", busy, 0);
        check("t1_valid_fin", bus.out_valid, 0);
        check("t1_i_hold", bus.i_out, 8'h11);
        nc();
        check("t1_done_pulse", done, 0);

        // Jump record with a stalled consumer and ignored starts.
        bus.out_ready = 1'b0; start = 1'b1; start_addr = 12'h020;
        nc();
        start = 1'b0;
        nc(); nc();
        check("t2_valid", bus.out_valid, 1);
        check("t2_i", bus.i_out, 8'hAA);
        check("t2_l", bus.l_out, 8'hDD);
        check("t2_addr_out", bus.addr_out, 12'h020);
        check("t2_pos", bus.pos_out, 4'h1);
        start = 1'b1; start_addr = 12'h123;
        for (int c = 0; c < 5; c++) begin
            nc();
            if (c == 0) start = 1'b0;
            check("t2_stall_valid", bus.out_valid, 1);
            check("t2_stall_i", bus.i_out, 8'hAA);
            check("t2_stall_ran", bus.ir_rd_ran, 0);
            check("t2_stall_seq", bus.ir_rd_seq, 0);
        end
        bus.out_ready = 1'b1;
        nc();
        check("t2_jump_ran", bus.ir_rd_ran, 1);
        check("t2_jump_addr", bus.ir_rd_addr, 12'h200);
        check("t2_jump_st_addr", bus.st_rd_addr, 12'h200);
        check("t2_valid_fall", bus.out_valid, 0);
        nc(); nc();
        check("t2_valid2", bus.out_valid, 1);
        check("t2_i2", bus.i_out, 8'h55);
        check("t2_l2", bus.l_out, 8'h88);
        check("t2_addr_out2", bus.addr_out, 12'h200);
        check("t2_pos2", bus.pos_out, 4'hF);
        start = 1'b1; start_addr = 12'h010;
        nc();
        check("t2_done", done, 1);
        check("t2_busy_fin", busy, 0);
        nc();
        check("t2_fin_start_busy", busy, 0);
        check("t2_fin_start_ran", bus.ir_rd_ran, 0);
        check("t2_done_pulse", done, 0);
        start = 1'b0;
        nc();
        check("t2_idle_busy", busy, 0);

        // Reset while capturing the first record.
        start = 1'b1; start_addr = 12'h010;
        nc();
        start = 1'b0;
        nc();
        rst = 1'b1;
        nc();
        check("t3_valid", bus.out_valid, 0);
        check("t3_busy", busy, 0);
        check("t3_done", done, 0);
        check("t3_i", bus.i_out, 0);
        check("t3_addr_out", bus.addr_out, 0);
        check("t3_pos", bus.pos_out, 0);
        check("t3_rd_addr", bus.ir_rd_addr, 0);
        rst = 1'b0;
        nc(); nc();
        check("t3_no_done", done, 0);
        check("t3_idle", busy, 0);

        // Jump target beyond DEPTH.
        start = 1'b1; start_addr = 12'h030;
        nc();
        start = 1'b0;
        nc(); nc();
        check("t4_valid", bus.out_valid, 1);
        check("t4_i", bus.i_out, 8'h0A);
        check("t4_addr_out", bus.addr_out, 12'h030);
        check("t4_pos", bus.pos_out, 4'h2);
`ifdef GET_PARAM_RANGE_CHK_EN
        check("t4_err", err, 1);
        nc();
        check("t4_done", done, 1);
        check("t4_no_ran", bus.ir_rd_ran, 0);
        check("t4_err_sticky", err, 1);
        nc();
        check("t4_done_pulse", done, 0);
        check("t4_err_idle", err, 1);
        start = 1'b1; start_addr = 12'h010;
        nc();
        start = 1'b0;
        check("t4_err_clear", err, 0);
        check("t4_busy_restart", busy, 1);
        repeat (6) nc();
        check("t4_restart_done", done, 1);
`else
        check("t4_err_tied", err, 0);
        nc();
        check("t4_jump_ran", bus.ir_rd_ran, 1);
        check("t4_jump_addr", bus.ir_rd_addr, 12'h300);
        check("t4_no_done", done, 0);
        nc(); nc();
        check("t4_valid2", bus.out_valid, 1);
        check("t4_i2", bus.i_out, 8'h01);
        check("t4_addr_out2", bus.addr_out, 12'h300);
        nc();
        check("t4_done", done, 1);
        check("t4_err_end", err, 0);
`endif
        nc();
        check("lockstep", lockstep_bad, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
